// File: rtl/led_pattern_sequencer.sv
// Table-driven sequencer for the LED blink block: each step holds a rate and
// enable for a programmed number of dwell ticks, then advances, loops or finishes.
module led_pattern_sequencer #(
  parameter int C_NUM_STEPS = 4,
  parameter int C_TICK_DIV  = 12500,
  parameter int C_DWELL_W   = 8
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_start,
  input  logic                           i_stop,
  input  logic                           i_loop,
  input  logic                           i_cfg_we,
  input  logic [$clog2(C_NUM_STEPS)-1:0] i_cfg_addr,
  input  logic [1:0]                     i_cfg_rate,
  input  logic                           i_cfg_en,
  input  logic [C_DWELL_W-1:0]           i_cfg_dwell,
  output logic                           o_switch_1,
  output logic                           o_switch_2,
  output logic                           o_enable,
  output logic                           o_busy,
  output logic [$clog2(C_NUM_STEPS)-1:0] o_step,
  output logic                           o_done
);

  localparam int SW = $clog2(C_NUM_STEPS);
  localparam int PW = $clog2(C_TICK_DIV);
  localparam logic [SW-1:0] LAST_STEP  = SW'(C_NUM_STEPS - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(C_TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  logic [1:0]           rate_tbl  [C_NUM_STEPS];
  logic                 en_tbl    [C_NUM_STEPS];
  logic [C_DWELL_W-1:0] dwell_tbl [C_NUM_STEPS];

  state_t               state, next_state;
  logic [SW-1:0]        step, next_step, step_inc;
  logic [PW-1:0]        presc;
  logic [C_DWELL_W-1:0] dwell_cnt;
  logic                 clear_cnt, step_end, last_step;

  // A step ends on the tick that completes its final dwell count.
  always_comb begin
    step_inc  = step + SW'(1);
    last_step = (step == LAST_STEP) || (dwell_tbl[step_inc] == '0);
    step_end  = (presc == PRESC_LAST) &&
                (dwell_cnt == dwell_tbl[step] - C_DWELL_W'(1));
  end

  always_comb begin
    next_state = state;
    next_step  = step;
    clear_cnt  = 1'b0;
    case (state)
      IDLE: begin
        next_step = '0;
        if (i_start && !i_stop) begin
          if (dwell_tbl[0] != '0) begin
            next_state = RUN;
            clear_cnt  = 1'b1;
          end else begin
            next_state = DONE;
          end
        end
      end
      RUN: begin
        if (i_stop) begin
          next_state = IDLE;
          next_step  = '0;
        end else if (step_end) begin
          clear_cnt = 1'b1;
          if (!last_step) begin
            next_step = step_inc;
          end else if (i_loop) begin
            next_step = '0;
          end else begin
            next_state = DONE;
            next_step  = '0;
          end
        end
      end
      DONE: begin
        next_state = IDLE;
        next_step  = '0;
      end
      default: begin
        next_state = IDLE;
        next_step  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
      step  <= '0;
    end else begin
      state <= next_state;
      step  <= next_step;
    end
  end

  // Counters restart on every step entry so each step gets its full dwell.
  always_ff @(posedge i_clock) begin
    if (i_reset || clear_cnt || state != RUN) begin
      presc     <= '0;
      dwell_cnt <= '0;
    end else if (presc == PRESC_LAST) begin
      presc     <= '0;
      dwell_cnt <= dwell_cnt + C_DWELL_W'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < C_NUM_STEPS; i++) begin
        rate_tbl[i]  <= 2'b00;
        en_tbl[i]    <= 1'b0;
        dwell_tbl[i] <= '0;
      end
    end else if (i_cfg_we && state != RUN) begin
      rate_tbl[i_cfg_addr]  <= i_cfg_rate;
      en_tbl[i_cfg_addr]    <= i_cfg_en;
      dwell_tbl[i_cfg_addr] <= i_cfg_dwell;
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_switch_1 <= 1'b0;
      o_switch_2 <= 1'b0;
      o_enable   <= 1'b0;
      o_busy     <= 1'b0;
      o_step     <= '0;
      o_done     <= 1'b0;
    end else begin
      o_busy <= (next_state == RUN);
      o_done <= (next_state == DONE);
      if (next_state == RUN) begin
        {o_switch_1, o_switch_2} <= rate_tbl[next_step];
        o_enable                 <= en_tbl[next_step];
        o_step                   <= next_step;
      end else begin
        {o_switch_1, o_switch_2} <= 2'b00;
        o_enable                 <= 1'b0;
        o_step                   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with a short tick divider so step
// timing, looping, stop, reset and table-protection behaviour are quick to hit.
module tb_led_pattern_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, stop, loop_en, cfg_we;
  logic [1:0] cfg_addr;
  logic [1:0] cfg_rate;
  logic       cfg_en;
  logic [7:0] cfg_dwell;
  logic       switch_1, switch_2, enable, busy, done;
  logic [1:0] step;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       start;
    logic       stop;
    logic [6:0] expOut;
  } vec_t;

  vec_t vecs [14];

  logic [1:0] rateTbl [4];
  logic       enTbl   [4];

  led_pattern_sequencer #(
    .C_NUM_STEPS(4),
    .C_TICK_DIV (4),
    .C_DWELL_W  (8)
  ) dut (
    .i_clock    (clk),
    .i_reset    (reset),
    .i_start    (start),
    .i_stop     (stop),
    .i_loop     (loop_en),
    .i_cfg_we   (cfg_we),
    .i_cfg_addr (cfg_addr),
    .i_cfg_rate (cfg_rate),
    .i_cfg_en   (cfg_en),
    .i_cfg_dwell(cfg_dwell),
    .o_switch_1 (switch_1),
    .o_switch_2 (switch_2),
    .o_enable   (enable),
    .o_busy     (busy),
    .o_step     (step),
    .o_done     (done)
  );

  always #5 clk = ~clk;

  // Packed as {sw1, sw2, enable, busy, step[1:0], done}.
  function automatic logic [6:0] expVec(input logic [1:0] rate, input logic en,
                                        input logic bsy, input logic [1:0] stp,
                                        input logic dn);
    return {rate, en, bsy, stp, dn};
  endfunction

  function automatic logic [6:0] runVec(input logic [1:0] stp);
    return expVec(rateTbl[stp], enTbl[stp], 1'b1, stp, 1'b0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [6:0] expOut);
    logic [6:0] act;
    act = {switch_1, switch_2, enable, busy, step, done};
    checks++;
    if (act !== expOut) begin
      failures++;
      $display("[TB] FAIL %s: got sw/en/busy/step/done=%b expected %b", name, act, expOut);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] addr, input logic [1:0] rate,
                               input logic en, input logic [7:0] dwell);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_rate  = rate;
    cfg_en    = en;
    cfg_dwell = dwell;
    tick();
    cfg_we = 1'b0;
    rateTbl[addr] = rate;
    enTbl[addr]   = en;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_rate = '0; cfg_en = 1'b0; cfg_dwell = '0;
    for (int i = 0; i < 4; i++) begin
      rateTbl[i] = 2'b00;
      enTbl[i]   = 1'b0;
    end
    tick(); tick();
    checkOutput("reset_state", 7'b0);
    reset = 1'b0;
    tick();
    checkOutput("idle_after_reset", 7'b0);

    // Basic two-step sequence, loop off.
    applyStimulus(2'd0, 2'b11, 1'b1, 8'd2);
    applyStimulus(2'd1, 2'b00, 1'b1, 8'd1);
    applyStimulus(2'd2, 2'b00, 1'b0, 8'd0);
    vecs[0] = '{1'b1, 1'b0, runVec(2'd0)};
    for (int i = 1; i < 8; i++) vecs[i] = '{1'b0, 1'b0, runVec(2'd0)};
    for (int i = 8; i < 12; i++) vecs[i] = '{1'b0, 1'b0, runVec(2'd1)};
    vecs[12] = '{1'b0, 1'b0, expVec(2'b00, 1'b0, 1'b0, 2'd0, 1'b1)};
    vecs[13] = '{1'b0, 1'b0, 7'b0};
    for (int i = 0; i < 14; i++) begin
      start = vecs[i].start;
      stop  = vecs[i].stop;
      tick();
      checkOutput($sformatf("basic_vec%0d", i), vecs[i].expOut);
    end

    // Loop mode: 8 cycles of step 0, 4 of step 1, repeating; start mid-run is ignored.
    loop_en = 1'b1;
    start   = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      start = (c == 4);
      checkOutput($sformatf("loop_c%0d", c), runVec(((c % 12) < 8) ? 2'd0 : 2'd1));
    end
    stop = 1'b1;
    tick();
    checkOutput("loop_stop", 7'b0);
    stop = 1'b0;
    tick();
    checkOutput("loop_stop_no_done", 7'b0);
    loop_en = 1'b0;

    // Full table, every dwell 1: terminates on the last index without a marker.
    applyStimulus(2'd0, 2'b01, 1'b1, 8'd1);
    applyStimulus(2'd1, 2'b10, 1'b0, 8'd1);
    applyStimulus(2'd2, 2'b11, 1'b1, 8'd1);
    applyStimulus(2'd3, 2'b00, 1'b1, 8'd1);
    start = 1'b1;
    for (int c = 0; c < 16; c++) begin
      tick();
      start = 1'b0;
      checkOutput($sformatf("full_c%0d", c), runVec(2'(c / 4)));
    end
    tick();
    checkOutput("full_done", expVec(2'b00, 1'b0, 1'b0, 2'd0, 1'b1));
    tick();
    checkOutput("full_idle", 7'b0);

    // Entry 0 empty: start goes straight to a done pulse.
    applyStimulus(2'd0, 2'b11, 1'b1, 8'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("empty_done", expVec(2'b00, 1'b0, 1'b0, 2'd0, 1'b1));
    tick();
    checkOutput("empty_idle", 7'b0);

    // Table write during RUN must be ignored.
    applyStimulus(2'd0, 2'b11, 1'b1, 8'd2);
    applyStimulus(2'd1, 2'b00, 1'b1, 8'd1);
    applyStimulus(2'd2, 2'b00, 1'b0, 8'd0);
    start = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      start = 1'b0;
      cfg_we    = (c == 1);
      cfg_addr  = 2'd1;
      cfg_rate  = 2'b11;
      cfg_en    = 1'b0;
      cfg_dwell = 8'd5;
      checkOutput($sformatf("runwrite_c%0d", c), runVec((c < 8) ? 2'd0 : 2'd1));
    end
    cfg_we = 1'b0;
    tick();
    checkOutput("runwrite_done", expVec(2'b00, 1'b0, 1'b0, 2'd0, 1'b1));
    tick();
    checkOutput("runwrite_idle", 7'b0);

    // Start and stop together in IDLE: stop wins.
    start = 1'b1;
    stop  = 1'b1;
    tick();
    checkOutput("startstop_idle", 7'b0);
    start = 1'b0;
    stop  = 1'b0;
    tick();
    checkOutput("startstop_still_idle", 7'b0);

    // Reset during step 1 clears outputs and the table.
    start = 1'b1;
    for (int c = 0; c < 9; c++) begin
      tick();
      start = 1'b0;
    end
    checkOutput("prereset_step1", runVec(2'd1));
    reset = 1'b1;
    tick();
    checkOutput("midrun_reset", 7'b0);
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("cleared_table_done", expVec(2'b00, 1'b0, 1'b0, 2'd0, 1'b1));
    tick();
    checkOutput("cleared_table_idle", 7'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_pattern_sequencer.md
# led_pattern_sequencer

Programmable sequencer that drives the rate-select switches and enable input of the LED blink block through a short table of steps. Each step holds one blink rate and one enable value for a programmed number of dwell ticks. Software or a top-level FSM loads the table, pulses start, and gets a done pulse at the end, or the sequence repeats in loop mode. The block sits between the board-level control logic and the blink block. Its outputs connect directly to that block's switch and enable inputs.

## Interface
- C_NUM_STEPS, 4: number of table entries (2..16); step index width is clog2(C_NUM_STEPS)
- C_TICK_DIV, 12500: clock cycles per dwell tick (≥2)
- C_DWELL_W, 8: width of per-step dwell count

- i_clock  in  1  clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  start request, sampled in IDLE only
- i_stop  in  1  abort request, sampled in RUN only
- i_loop  in  1  repeat sequence at end instead of finishing
- i_cfg_we  in  1  table write strobe
- i_cfg_addr  in  clog2(C_NUM_STEPS)  table entry to write
- i_cfg_rate  in  2  {switch_1, switch_2} for the entry
- i_cfg_en  in  1  LED enable for the entry
- i_cfg_dwell  in  C_DWELL_W  dwell in ticks; 0 = end-of-sequence marker
- o_switch_1  out  1  to blink block i_switch_1
- o_switch_2  out  1  to blink block i_switch_2
- o_enable  out  1  to blink block i_enable
- o_busy  out  1  high in RUN
- o_step  out  clog2(C_NUM_STEPS)  current step index
- o_done  out  1  one-cycle pulse at normal sequence completion

## Operation
- States: IDLE, RUN, DONE. Reset puts the block in IDLE. Reset clears every table entry to rate 00, en 0, dwell 0.
- Reset output values: o_switch_1=0, o_switch_2=0, o_enable=0, o_busy=0, o_step=0, o_done=0. All outputs are registered.
- Table writes are accepted only in IDLE and DONE. i_cfg_we in RUN is ignored and the table is unchanged.
- IDLE: if i_start=1 and i_stop=0:
  - entry 0 dwell ≠ 0: go to RUN at step 0.
  - entry 0 dwell = 0: go straight to DONE.
  - i_start and i_stop both high in IDLE: stop wins and the block stays in IDLE.
- RUN: outputs carry the current entry's rate and enable.
  - A prescaler counts 0..C_TICK_DIV-1 and produces a tick on terminal count.
  - A dwell counter counts ticks. Both counters clear on every step entry.
  - Step k lasts exactly dwell_k × C_TICK_DIV cycles.
- End of step k: next = k+1, unless k = C_NUM_STEPS-1 or entry k+1 has dwell 0. In either of those cases it is end of sequence.
- End of sequence: i_loop is sampled in the final cycle of the step.
  - i_loop=1: wrap to step 0. Entry 0 dwell is ≠ 0 by construction.
  - i_loop=0: go to DONE.
- i_stop=1 in RUN: go to IDLE next cycle. Outputs return to reset values and no o_done is produced. Stop takes priority over step advance in the same cycle.
- i_start in RUN is ignored. Start does not restart the sequence.
- DONE: lasts one cycle with o_done=1, o_enable=0, switches 00, o_busy=0, then goes to IDLE. i_start in DONE is ignored.
- Counters are at least C_DWELL_W + clog2(C_TICK_DIV) bits wide in total and must never wrap inside a step.

## Timing
- Start latency: i_start high in cycle N puts the state in RUN in cycle N+1. o_busy=1 and step 0 outputs are valid in N+1.
- Step boundary: the last cycle of step k is followed directly by step k+1's outputs. There are no gap cycles and o_enable never glitches to 0 between enabled steps.
- Completion: o_done is high in the cycle after the last step's final cycle. o_busy falls in that same cycle.
- Stop latency: i_stop in cycle N puts outputs at reset values in cycle N+1.
- Reset mid-RUN: asserting i_reset in cycle N gives all reset values in N+1 and clears the table.

## Test plan
- C_TICK_DIV=4. Table {rate 11 en1 dwell2, rate 00 en1 dwell1, dwell0}, loop=0, start pulse → step 0 for 8 cycles, then step 1 for 4 cycles. Switches show 11 then 00. o_done high exactly one cycle later; o_busy low in that cycle.
- Same table with i_loop=1 → step sequence 0,1,0,1,… with no gap cycles and o_done never asserts. Then i_stop → IDLE next cycle, o_enable=0, no o_done.
- Full table, 4 entries each dwell 1, loop=0 → steps 0..3 for 4 cycles each, then o_done. This checks last-index termination without a zero marker.
- Entry 0 dwell 0, start → o_busy never asserts and o_done pulses in the cycle after start.
- Write entry 1 with dwell 5 during RUN → the table is unchanged and the step keeps its old dwell. Also check i_start and i_stop in the same IDLE cycle → the block stays in IDLE.
- i_reset asserted during step 1 → the next cycle has all outputs at reset values. A following start with no rewrite produces an immediate o_done, because the table was cleared.
